// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S frame receiver.
// Holds the receive FSM encoding, channel codes and bit counter sizing.
// No logic of its own; imported by the receiver files.
package i2s_pkg;

  // Receive FSM: hunting for a left-slot start, or inside a channel slot
  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    RX_LEFT  = 2'd1,
    RX_RIGHT = 2'd2
  } rx_state_t;

  // Word-select encoding on i2s_lrclk
  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

  // Bits received in the current slot; wide enough for SLOT_MAX up to 63
  localparam int BITCNT_W = 6;
  typedef logic [BITCNT_W-1:0] bitcnt_t;

  // Receive state that owns a slot carrying the given word-select level
  function automatic rx_state_t slot_state(input logic lr);
    return (lr == LR_RIGHT) ? RX_RIGHT : RX_LEFT;
  endfunction

endpackage

// File: rtl/i2s_pin_sync.sv
// Purpose: bring sclk/lrclk/sd into the clk domain and flag sclk rising edges.
// Latency: 2-3 clk from a pin edge to the o_bit_evt strobe.
// Backpressure: none; free-running sampler.
import i2s_pkg::*;

module i2s_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sclk,
  input  logic i_lrclk,
  input  logic i_sd,
  output logic o_bit_evt,
  output logic o_lrclk,
  output logic o_sd
);

  // [0] = first stage, [1] = second stage, [2] = edge-detect history (sclk only)
  logic [2:0] r_sclk_sync;
  logic [1:0] r_lr_sync;
  logic [1:0] r_sd_sync;

  // Two-flop synchronizers on every pin plus one history flop on sclk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_lr_sync   <= '0;
      r_sd_sync   <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], i_sclk};
      r_lr_sync   <= {r_lr_sync[0], i_lrclk};
      r_sd_sync   <= {r_sd_sync[0], i_sd};
    end
  end

  // lrclk and sd changed on the falling sclk edge, so their second stage is
  // settled by the time the rising edge reaches the same depth.
  assign o_bit_evt = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign o_lrclk   = r_lr_sync[1];
  assign o_sd      = r_sd_sync[1];

endmodule

// File: rtl/i2s_frame_receiver.sv
// Purpose: deserialize a Philips I2S stream into left/right sample pairs.
// Latency: frame valid 1 clk after the sclk event that carries the right LSB.
// Backpressure: none upstream; an unconsumed frame is overwritten by the next.
// Optional: define I2S_RX_OVERRUN_EN to build the sticky overrun flag.
import i2s_pkg::*;

module i2s_frame_receiver #(
  parameter int WIDTH    = 16,
  parameter int SLOT_MAX = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i2s_sclk,
  input  logic             i2s_lrclk,
  input  logic             i2s_sd,
  output logic [WIDTH-1:0] left_data,
  output logic [WIDTH-1:0] right_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             locked,
  output logic             overrun,
  input  logic             overrun_clr
);

  // Counter value at which one more bit without a channel change means the
  // slot is longer than SLOT_MAX.
  localparam bitcnt_t SLOT_LAST = bitcnt_t'(SLOT_MAX - 1);

  logic             w_bit_evt;
  logic             w_lr;
  logic             w_sd;
  logic             w_trans;

  logic             r_lr_prev;
  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_word;
  bitcnt_t          r_bitcnt;
  bitcnt_t          w_bitcnt_nxt;
  logic             w_hold_ld;
  logic             w_frame_done;

  logic [WIDTH-1:0] r_left_hold;
  logic [WIDTH-1:0] r_left_data;
  logic [WIDTH-1:0] r_right_data;
  logic             r_out_valid;
  logic             r_locked;

  i2s_pin_sync u_pin_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_sclk    (i2s_sclk),
    .i_lrclk   (i2s_lrclk),
    .i_sd      (i2s_sd),
    .o_bit_evt (w_bit_evt),
    .o_lrclk   (w_lr),
    .o_sd      (w_sd)
  );

  assign w_trans = (w_lr != r_lr_prev);

  // Track the word-select level seen at the previous bit event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lr_prev <= LR_LEFT;
    end else if (w_bit_evt) begin
      r_lr_prev <= w_lr;
    end
  end

  // Current word with this event's bit merged in; bits past WIDTH fall off
  always_comb begin
    w_word = r_shift;
    for (int i = 0; i < WIDTH; i++) begin
      if (int'(r_bitcnt) == WIDTH - 1 - i) begin
        w_word[i] = w_sd;
      end
    end
  end

  // FSM state, shift register and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= HUNT;
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
    end
  end

  // Next state and word-completion strobes, evaluated only on bit events
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_hold_ld    = 1'b0;
    w_frame_done = 1'b0;
    if (w_bit_evt) begin
      case (r_state)
        HUNT: begin
          // Only a move into the left channel marks a usable frame start
          if (w_trans && (w_lr == LR_LEFT)) begin
            w_shift_nxt  = '0;
            w_bitcnt_nxt = '0;
            w_state_nxt  = RX_LEFT;
          end
        end
        RX_LEFT, RX_RIGHT: begin
          if (w_trans) begin
            // This bit is the LSB of the word that is ending
            w_shift_nxt  = '0;
            w_bitcnt_nxt = '0;
            if (r_bitcnt == '0) begin
              w_state_nxt = HUNT;
            end else begin
              w_state_nxt = slot_state(w_lr);
              if (r_state == RX_LEFT) begin
                w_hold_ld = 1'b1;
              end else begin
                w_frame_done = 1'b1;
              end
            end
          end else if (r_bitcnt == SLOT_LAST) begin
            // Slot ran too long: drop the partial frame and resynchronize
            w_shift_nxt  = '0;
            w_bitcnt_nxt = '0;
            w_state_nxt  = HUNT;
          end else begin
            w_shift_nxt  = w_word;
            w_bitcnt_nxt = r_bitcnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = HUNT;
        end
      endcase
    end
  end

  // Left holding register, output frame, valid handshake and lock flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_left_hold  <= '0;
      r_left_data  <= '0;
      r_right_data <= '0;
      r_out_valid  <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      if (w_hold_ld) begin
        r_left_hold <= w_word;
      end
      if (w_frame_done) begin
        r_left_data  <= r_left_hold;
        r_right_data <= w_word;
      end
      // A completing frame keeps valid high even on the transfer cycle
      r_out_valid <= w_frame_done | (r_out_valid & ~out_ready);
      if (w_state_nxt == HUNT) begin
        r_locked <= 1'b0;
      end else if (w_frame_done) begin
        r_locked <= 1'b1;
      end
    end
  end

  assign left_data  = r_left_data;
  assign right_data = r_right_data;
  assign out_valid  = r_out_valid;
  assign locked     = r_locked;

`ifdef I2S_RX_OVERRUN_EN
  logic r_overrun;
  logic w_ovr_set;

  assign w_ovr_set = w_frame_done & r_out_valid & ~out_ready;

  // Sticky overrun; a new overwrite beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign overrun = r_overrun;
`else
  logic w_unused_ovr_clr;

  assign w_unused_ovr_clr = overrun_clr;
  assign overrun          = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_frame_receiver.sv
// Bench for i2s_frame_receiver: table vectors, corner sequences, random frames.
// Pins are driven from a per-sclk bit stream built from slot descriptions.
// Received frames are collected by a monitor and compared to expectations.
module tb_i2s_frame_receiver;

  localparam int W  = 16;
  localparam int SM = 32;
`ifdef I2S_RX_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i2s_sclk;
  logic         i2s_lrclk;
  logic         i2s_sd;
  logic [W-1:0] left_data;
  logic [W-1:0] right_data;
  logic         out_valid;
  logic         out_ready;
  logic         locked;
  logic         overrun;
  logic         overrun_clr;

  i2s_frame_receiver #(.WIDTH(W), .SLOT_MAX(SM)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i2s_sclk    (i2s_sclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_sd      (i2s_sd),
    .left_data   (left_data),
    .right_data  (right_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .locked      (locked),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int half   = 4;  // clk cycles per sclk phase

  bit          lr_q[$];
  bit          dat_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] rx_q[$];

  // Record every accepted frame, sampled well away from the clock edges
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) rx_q.push_back({left_data, right_data});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One slot: word bits MSB first, all carried with the slot's lrclk level
  task automatic add_slot(input bit lr, input int len, input logic [63:0] word);
    for (int i = len - 1; i >= 0; i--) begin
      lr_q.push_back(lr);
      dat_q.push_back(word[i]);
    end
  endtask

  // Reference: the word is left-aligned into W bits, truncated or zero padded
  function automatic logic [W-1:0] fit(input int len, input logic [63:0] w);
    if (len >= W) return W'(w >> (len - W));
    return W'(w << (W - len));
  endfunction

  task automatic add_frame(input int ll, input logic [63:0] lw, input int rl, input logic [63:0] rw);
    add_slot(1'b0, ll, lw);
    add_slot(1'b1, rl, rw);
    exp_q.push_back({fit(ll, lw), fit(rl, rw)});
  endtask

  task automatic new_stream();
    lr_q.delete();
    dat_q.delete();
    exp_q.delete();
    rx_q.delete();
  endtask

  // Data lags lrclk by one sclk, which is the I2S one-bit delay
  task automatic play(input int from, input int to);
    for (int t = from; t < to; t++) begin
      i2s_sclk  = 1'b0;
      i2s_lrclk = lr_q[t];
      i2s_sd    = (t == 0) ? 1'b0 : dat_q[t-1];
      repeat (half) @(negedge clk);
      i2s_sclk = 1'b1;
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    i2s_sclk  = 1'b0;
    i2s_lrclk = 1'b0;
    i2s_sd    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic finish_check(input string tag);
    repeat (12) @(negedge clk);
    check({tag, " count"}, 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      check({tag, " left"},  64'(rx_q[i][31:16]), 64'(exp_q[i][31:16]));
      check({tag, " right"}, 64'(rx_q[i][15:0]),  64'(exp_q[i][15:0]));
    end
    check({tag, " locked"}, 64'(locked), 64'd1);
  endtask

  typedef struct {
    int           len;
    logic [63:0]  lw;
    logic [63:0]  rw;
    logic [W-1:0] el;
    logic [W-1:0] er;
  } vec_t;

  vec_t vt[6];

  initial begin
    int cut;
    int cut2;
    int ll;
    int rl;
    logic [63:0] lw;
    logic [63:0] rw;

    vt[0] = '{32, 64'hA5C30000, 64'h12340000, 16'hA5C3, 16'h1234};
    vt[1] = '{12, 64'h00000ABC, 64'h00000123, 16'hABC0, 16'h1230};
    vt[2] = '{24, 64'h0089ABCD, 64'h00456789, 16'h89AB, 16'h4567};
    vt[3] = '{16, 64'h0000FFFF, 64'h00000001, 16'hFFFF, 16'h0001};
    vt[4] = '{2,  64'h00000002, 64'h00000001, 16'h8000, 16'h4000};
    vt[5] = '{17, 64'h0001FFFE, 64'h00000001, 16'hFFFF, 16'h0000};

    rst_n       = 1'b0;
    i2s_sclk    = 1'b0;
    i2s_lrclk   = 1'b0;
    i2s_sd      = 1'b0;
    out_ready   = 1'b1;
    overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset left",    64'(left_data),  64'd0);
    check("reset right",   64'(right_data), 64'd0);
    check("reset valid",   64'(out_valid),  64'd0);
    check("reset locked",  64'(locked),     64'd0);
    check("reset overrun", 64'(overrun),    64'd0);

    // Table: two identical frames per vector behind a short right-slot tail
    for (int v = 0; v < 6; v++) begin
      do_reset();
      new_stream();
      add_slot(1'b1, 4, 64'h5);
      for (int f = 0; f < 2; f++) begin
        add_slot(1'b0, vt[v].len, vt[v].lw);
        add_slot(1'b1, vt[v].len, vt[v].rw);
        exp_q.push_back({vt[v].el, vt[v].er});
      end
      add_slot(1'b0, 3, 64'h0);
      play(0, lr_q.size());
      finish_check($sformatf("vec%0d", v));
    end

    // Stream begins mid left slot: that partial left and its right are dropped
    do_reset();
    new_stream();
    add_slot(1'b0, 10, 64'h3FF);
    add_slot(1'b1, 32, 64'hDEADBEEF);
    add_frame(32, 64'hA5C30000, 32, 64'h12340000);
    add_slot(1'b0, 3, 64'h0);
    play(0, lr_q.size());
    finish_check("midstart");

    // Over-long right slot loses lock; next left start recovers
    do_reset();
    new_stream();
    add_slot(1'b1, 4, 64'h0);
    add_frame(32, 64'h11110000, 32, 64'h22220000);
    add_slot(1'b0, 32, 64'h33330000);
    cut = lr_q.size();
    add_slot(1'b1, 40, 64'hFF_FFFF_FFFF);
    cut2 = lr_q.size();
    add_frame(32, 64'h55550000, 32, 64'h66660000);
    add_slot(1'b0, 3, 64'h0);
    play(0, cut);
    check("loss locked before", 64'(locked), 64'd1);
    play(cut, cut2);
    repeat (4) @(negedge clk);
    check("loss locked after", 64'(locked), 64'd0);
    play(cut2, lr_q.size());
    finish_check("loss");

    // Backpressure across two frames, newest frame wins
    do_reset();
    new_stream();
    out_ready = 1'b0;
    add_slot(1'b1, 4, 64'h0);
    add_slot(1'b0, 16, 64'h1111);
    add_slot(1'b1, 16, 64'h2222);
    add_slot(1'b0, 16, 64'h3333);
    add_slot(1'b1, 16, 64'h4444);
    add_slot(1'b0, 3, 64'h0);
    play(0, lr_q.size());
    repeat (8) @(negedge clk);
    check("bp valid",   64'(out_valid),  64'd1);
    check("bp left",    64'(left_data),  64'h3333);
    check("bp right",   64'(right_data), 64'h4444);
    check("bp overrun", 64'(overrun),    64'(OVR_EXP));
    repeat (5) @(negedge clk);
    check("bp overrun held", 64'(overrun), 64'(OVR_EXP));
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("bp overrun clr", 64'(overrun),   64'd0);
    check("bp valid kept",  64'(out_valid), 64'd1);
    check("bp none taken",  64'(rx_q.size()), 64'd0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("bp taken", 64'(rx_q.size()), 64'd1);
    check("bp valid drop", 64'(out_valid), 64'd0);

    // Asynchronous reset in the middle of a right slot
    do_reset();
    new_stream();
    add_slot(1'b1, 4, 64'h0);
    add_frame(32, 64'hA5C30000, 32, 64'h12340000);
    add_slot(1'b0, 32, 64'h77770000);
    add_slot(1'b1, 10, 64'h2AA);
    play(0, lr_q.size());
    check("pre-rst left", 64'(left_data), 64'hA5C3);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid-rst left",   64'(left_data),  64'd0);
    check("mid-rst right",  64'(right_data), 64'd0);
    check("mid-rst valid",  64'(out_valid),  64'd0);
    check("mid-rst locked", 64'(locked),     64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    new_stream();
    add_slot(1'b1, 22, 64'h155555);
    add_frame(32, 64'h0F0F0000, 32, 64'hF0F00000);
    add_slot(1'b0, 3, 64'h0);
    play(0, lr_q.size());
    finish_check("postrst");

    // Random slot lengths and data at the minimum 4x oversampling ratio
    half = 2;
    do_reset();
    new_stream();
    add_slot(1'b1, $urandom_range(2, 8), 64'(
      $urandom));
    for (int f = 0; f < 8; f++) begin
      ll = $urandom_range(4, 32);
      rl = $urandom_range(4, 32);
      lw = {$urandom, $urandom} & ((64'd1 << ll) - 64'd1);
      rw = {$urandom, $urandom} & ((64'd1 << rl) - 64'd1);
      add_frame(ll, lw, rl, rw);
    end
    add_slot(1'b0, 3, 64'h0);
    play(0, lr_q.size());
    finish_check("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_frame_receiver.md
Name: i2s_frame_receiver

Overview:
- Deserializes a standard Philips I2S stream, the same format as the supermic I2S output, back into parallel left/right samples.
- Sits on the test/loopback side: it captures the array's `i2s_out` with its `lr_clk` and bit clock, and hands complete stereo frames to downstream logic over a valid/ready handshake.
- The receiver is oversampled: all I2S pins are sampled in the `clk` domain; no logic is clocked by the bit clock.

Parameters:
- WIDTH, 16, output sample width in bits (8..32).
- SLOT_MAX, 32, maximum bits per channel slot before the receiver declares loss of sync (WIDTH..63).

Ports:
- clk  in  1  system clock; must run at ≥4× the I2S bit clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i2s_sclk  in  1  I2S bit clock, asynchronous to clk.
- i2s_lrclk  in  1  word select: 0 = left, 1 = right.
- i2s_sd  in  1  serial data, MSB first.
- left_data  out  WIDTH  last complete left sample.
- right_data  out  WIDTH  last complete right sample.
- out_valid  out  1  frame available.
- out_ready  in  1  consumer accepts the frame.
- locked  out  1  receiver is aligned to frames.
- overrun  out  1  sticky overrun flag (see Optional Feature).
- overrun_clr  in  1  clears overrun.

Behaviour:
- Clocking and reset: one clock `clk`. Reset is asynchronous and active-low (`rst_n`). In reset, every register and output is 0, and the FSM is in HUNT.
- Synchronizers: `i2s_sclk`, `i2s_lrclk` and `i2s_sd` each pass through 2 flops, plus a third flop on sclk for edge detection.
  - Edge event E occurs on the clk cycle where sync2_sclk=1 and sync3_sclk=0.
  - lrclk and sd are taken from their sync2 stage in cycle E.
  - Pin-to-E latency is 2–3 clk.
- lr_prev register: updates to the sampled lrclk at every E. Transition T = (sampled lrclk != lr_prev).
- I2S one-bit delay: the bit sampled at an E carrying T is the LSB of the word that is ending. The MSB of the new word arrives at the next E.
- FSM HUNT:
  - `locked` = 0; no capture.
  - At E with T and sampled lrclk = 0 (left slot start): clear `shift_reg`, set bitcnt=0, go to RX_LEFT.
- FSM RX_LEFT / RX_RIGHT, at each E:
  - Without T: if bitcnt < WIDTH, write sd to `shift_reg[WIDTH-1-bitcnt]`. Then bitcnt++.
  - With T: store the final bit by the same rule, then finish the word.
    - RX_LEFT: copy `shift_reg` to the left holding register; go to RX_RIGHT.
    - RX_RIGHT: copy to `right_data`, copy the held left value to `left_data`, and set `out_valid` at E+1. Go to RX_LEFT.
    - In both cases clear `shift_reg` and set bitcnt=0.
- Slot length handling:
  - Slot shorter than WIDTH: the word is left-aligned with zero LSB padding.
  - Slot longer than WIDTH: excess LSBs are dropped.
- Loss of sync: if bitcnt reaches SLOT_MAX without T, or a word ends with bitcnt = 0 (zero-length slot), go to HUNT. `locked` = 0 and the partial frame is discarded.
- `locked` = 1 while in RX_LEFT/RX_RIGHT and at least one full frame has been delivered since leaving HUNT.
- Handshake:
  - A frame transfers on a cycle with `out_valid` & `out_ready`; `out_valid` then drops next cycle unless a new frame completes in that same cycle, in which case it stays 1 with the new data.
  - If a frame completes while `out_valid`=1 and not consumed, the data is overwritten with the newest frame and `out_valid` stays 1.
  - `left_data` and `right_data` are stable while `out_valid`=1 except on that overwrite.
- Reset mid-frame: asynchronous clear to the reset state; alignment is re-acquired from the next left-slot start.

Optional Feature:
- Macro: `I2S_RX_OVERRUN_EN`.
- Defined:
  - `overrun` sets when a frame overwrites an unconsumed frame.
  - It stays set until `overrun_clr`=1; it clears on the cycle after `overrun_clr`.
  - If set and clear coincide, set wins.
- Not defined: `overrun` is tied to 0, `overrun_clr` is ignored, and no overrun logic is built.

Decomposition:
- Shared package `i2s_pkg` holds:
  - the FSM state enum (HUNT, RX_LEFT, RX_RIGHT);
  - the channel encoding constants LR_LEFT=0, LR_RIGHT=1;
  - the bitcnt width constant (6 bits).
- One sub-module, `i2s_pin_sync`: the 3-flop synchronizer for the three pins. It outputs the sclk rise strobe and the aligned lrclk/sd samples.

Test Plan:
- Reset, then 2 frames at 32 bits/slot and clk = 8× sclk, L=0xA5C3 and R=0x1234, with `out_ready`=1 → `locked`=1 after frame 1. `out_valid` pulses 1 cycle per frame with `left_data`=0xA5C3 and `right_data`=0x1234.
- Stream starts mid right slot → first partial frame is discarded. First `out_valid` comes only after a complete left+right pair; data is correct.
- 12-bit slots, WIDTH=16, L bits 0xABC → `left_data`=0xABC0. 24-bit slots, WIDTH=16, L=0x89ABCD → 0x89AB.
- lrclk held at 1 for 40 sclk (SLOT_MAX=32) → `locked`=0 and FSM in HUNT. Recovers on the next 1→0 transition plus a full frame.
- `out_ready`=0 across 2 frames → `out_valid` stays 1 and the data equals frame 2. With `I2S_RX_OVERRUN_EN`, `overrun`=1 until `overrun_clr` pulses. Without it, `overrun` stays 0.
- `rst_n` asserted mid right slot → all outputs 0 immediately. After release, the first `out_valid` occurs only after a fresh full frame.
